// File: rtl/roce_pkg.sv
// Shared RoCE definitions: PSN width, RC opcodes, PSN-window FSM encoding.
package roce_pkg;

  localparam int PSN_WIDTH = 24;

  typedef logic [PSN_WIDTH-1:0] psn_t;

  localparam logic [7:0] RC_SEND_FIRST        = 8'h00;
  localparam logic [7:0] RC_SEND_MIDDLE       = 8'h01;
  localparam logic [7:0] RC_SEND_LAST         = 8'h02;
  localparam logic [7:0] RC_SEND_ONLY         = 8'h04;
  localparam logic [7:0] RC_RDMA_WRITE_FIRST  = 8'h06;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY   = 8'h0A;
  localparam logic [7:0] RC_RDMA_READ_REQUEST = 8'h0C;
  localparam logic [7:0] RC_ACKNOWLEDGE       = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RETRY = 2'd2,
    ST_ERROR = 2'd3
  } win_state_e;

  // PSN successor in the 24-bit sequence space (wraps naturally).
  function automatic psn_t psn_inc(input psn_t p);
    return p + 24'd1;
  endfunction

endpackage

// File: rtl/roce_tx_psn_window_if.sv
// BTH header handshake bundle (valid/ready plus PSN and opcode).
interface roce_tx_psn_window_if;
  import roce_pkg::*;

  logic       valid;
  logic       ready;
  psn_t       psn;
  logic [7:0] op_code;

  modport master (output valid, psn, op_code, input ready);
  modport slave  (input valid, psn, op_code, output ready);
endinterface

// File: rtl/roce_retry_timer.sv
// Saturating ACK-timeout counter with synchronous clear and gated expiry.
module roce_retry_timer #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [TIMER_WIDTH-1:0] cfg_timeout,
  output logic                   expire
);

  localparam logic [TIMER_WIDTH-1:0] CNT_MAX = {TIMER_WIDTH{1'b1}};

  logic [TIMER_WIDTH-1:0] count_r;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {TIMER_WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {TIMER_WIDTH{1'b0}};
    end else if (enable && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // A clear in the same cycle (ACK progress) suppresses expiry.
  assign expire = enable & ~clear & (count_r == cfg_timeout);

endmodule

// File: rtl/roce_tx_psn_window.sv
// RoCE TX PSN window: throttles BTHs to WINDOW_SIZE unacked PSNs and drives
// go-back-N retransmission on ACK timeout or NAK, with a retry limit.
module roce_tx_psn_window
  import roce_pkg::*;
#(
  parameter int WINDOW_SIZE = 16,
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rst_qp,
  input  psn_t                   qp_init_rem_psn,
  roce_tx_psn_window_if.slave    s_tx_bth,
  roce_tx_psn_window_if.master   m_tx_bth,
  input  psn_t                   last_acked_psn,
  input  logic                   stop_transfer,
  input  logic [TIMER_WIDTH-1:0] cfg_timeout,
  input  logic [2:0]             cfg_max_retries,
  output logic                   retx_valid,
  input  logic                   retx_ready,
  output psn_t                   retx_psn,
  output psn_t                   outstanding,
  output logic                   qp_error,
  output logic                   timeout_event
);

  localparam psn_t WIN_PSN = psn_t'(WINDOW_SIZE);

  win_state_e state_r;
  psn_t       sent_psn_r;
  psn_t       outstanding_r;
  psn_t       prev_ack_r;
  psn_t       retx_psn_r;
  psn_t       sent_next_s;
  logic [2:0] retry_cnt_r;
  logic [2:0] retry_base_s;
  logic       stop_prev_r;
  logic       retx_valid_r;
  logic       qp_error_r;
  logic       timeout_event_r;
  logic       allow_s;
  logic       s_fire_s;
  logic       retx_fire_s;
  logic       ack_changed_s;
  logic       nak_edge_s;
  logic       expire_s;
  logic       timer_clear_s;
  logic       timer_en_s;

  assign allow_s        = (state_r == ST_RUN) && (outstanding_r < WIN_PSN);
  assign m_tx_bth.valid   = s_tx_bth.valid & allow_s;
  assign m_tx_bth.psn     = s_tx_bth.psn;
  assign m_tx_bth.op_code = s_tx_bth.op_code;
  assign s_tx_bth.ready   = m_tx_bth.ready & allow_s;

  assign s_fire_s      = s_tx_bth.valid & s_tx_bth.ready;
  assign retx_fire_s   = (state_r == ST_RETRY) & retx_valid_r & retx_ready;
  assign ack_changed_s = (last_acked_psn != prev_ack_r);
  assign nak_edge_s    = stop_transfer & ~stop_prev_r;
  // Forward progress resets the retry budget before this cycle's retry decision.
  assign retry_base_s  = ack_changed_s ? 3'd0 : retry_cnt_r;
  assign timer_en_s    = (state_r == ST_RUN) && (outstanding_r != 24'd0);
  assign timer_clear_s = rst_qp | (outstanding_r == 24'd0) | ack_changed_s | retx_fire_s;

  roce_retry_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (timer_clear_s),
    .enable      (timer_en_s),
    .cfg_timeout (cfg_timeout),
    .expire      (expire_s)
  );

  // Next value of the last-sent PSN: QP init, accepted BTH, or rewind on retransmit.
  always_comb begin
    sent_next_s = sent_psn_r;
    if (rst_qp) begin
      sent_next_s = qp_init_rem_psn;
    end else if (s_fire_s) begin
      sent_next_s = s_tx_bth.psn;
    end else if (retx_fire_s) begin
      sent_next_s = last_acked_psn;
    end else begin
      sent_next_s = sent_psn_r;
    end
  end

  // Window state machine, PSN tracking and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      sent_psn_r      <= 24'd0;
      outstanding_r   <= 24'd0;
      prev_ack_r      <= 24'd0;
      retx_psn_r      <= 24'd0;
      retry_cnt_r     <= 3'd0;
      stop_prev_r     <= 1'b0;
      retx_valid_r    <= 1'b0;
      qp_error_r      <= 1'b0;
      timeout_event_r <= 1'b0;
    end else begin
      prev_ack_r      <= last_acked_psn;
      stop_prev_r     <= stop_transfer;
      sent_psn_r      <= sent_next_s;
      // Computed from the next sent PSN so the window never over-issues.
      outstanding_r   <= sent_next_s - last_acked_psn;
      timeout_event_r <= 1'b0;
      if (rst_qp) begin
        state_r      <= ST_RUN;
        retry_cnt_r  <= 3'd0;
        retx_valid_r <= 1'b0;
        qp_error_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_RUN: begin
            timeout_event_r <= expire_s;
            if (expire_s || nak_edge_s) begin
              if (retry_base_s == cfg_max_retries) begin
                state_r     <= ST_ERROR;
                qp_error_r  <= 1'b1;
                retry_cnt_r <= retry_base_s;
              end else begin
                state_r      <= ST_RETRY;
                retry_cnt_r  <= retry_base_s + 3'd1;
                retx_valid_r <= 1'b1;
                retx_psn_r   <= psn_inc(last_acked_psn);
              end
            end else begin
              retry_cnt_r <= retry_base_s;
            end
          end
          ST_RETRY: begin
            retry_cnt_r <= retry_base_s;
            if (retx_fire_s) begin
              retx_valid_r <= 1'b0;
              state_r      <= ST_RUN;
            end else begin
              retx_valid_r <= 1'b1;
            end
          end
          ST_ERROR: begin
            retry_cnt_r <= retry_base_s;
            qp_error_r  <= 1'b1;
          end
          default: begin
            state_r      <= ST_IDLE;
            retx_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign retx_valid    = retx_valid_r;
  assign retx_psn      = retx_psn_r;
  assign outstanding   = outstanding_r;
  assign qp_error      = qp_error_r;
  assign timeout_event = timeout_event_r;

endmodule
